axi_stream_protocol_checker: RTL and testbench

//  Synthesizable AXI4-Stream protocol checker. Watches one stream link (same wires as the master-side property set)
//  and latches sticky error flags, first-error code and beat/packet statistics as outputs.

---
 rtl/axi_stream_protocol_checker.sv | 178 +++++++++++++++++
 tb/tb_axi_stream_protocol_checker.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/axi_stream_protocol_checker.sv
// AXI4-Stream protocol checker. Passive observer of one stream link.
// It latches sticky violation flags, records the first violation seen since the
// last clear, and keeps saturating beat and packet statistics.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | no packet open; the next accepted beat starts a packet
// IN_PACKET | packet open; route latched; waiting for the tlast beat
module axi_stream_protocol_checker #(
  parameter int byte_width       = 4,
  parameter int id_width         = 0,
  parameter int dest_width       = 0,
  parameter int user_width       = 0,
  parameter int MAX_PACKET_BEATS = 0,
  parameter int STALL_TIMEOUT    = 0,
  parameter int COUNT_WIDTH      = 32
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      tvalid,
  input  logic                                      tready,
  input  logic [8*byte_width-1:0]                   tdata,
  input  logic [byte_width-1:0]                     tstrb,
  input  logic [byte_width-1:0]                     tkeep,
  input  logic                                      tlast,
  input  logic [((id_width > 0) ? id_width : 1)-1:0]     tid,
  input  logic [((dest_width > 0) ? dest_width : 1)-1:0] tdest,
  input  logic [((user_width > 0) ? user_width : 1)-1:0] tuser,
  input  logic                                      clear_errors,
  output logic [5:0]                                err_flags,
  output logic                                      err_any,
  output logic [2:0]                                first_err,
  output logic [COUNT_WIDTH-1:0]                    beat_count,
  output logic [COUNT_WIDTH-1:0]                    packet_count,
  output logic                                      in_packet
);

  localparam int ID_W   = (id_width > 0) ? id_width : 1;
  localparam int DEST_W = (dest_width > 0) ? dest_width : 1;
  localparam int USER_W = (user_width > 0) ? user_width : 1;
  // One spare count above the limit so an over-long packet is still visible.
  localparam int PB_W   = $clog2(MAX_PACKET_BEATS + 2);
  localparam int ST_W   = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;
  localparam logic [PB_W-1:0] MAX_PB = PB_W'(MAX_PACKET_BEATS);
  localparam logic [ST_W-1:0] ST_MAX = ST_W'(STALL_TIMEOUT);

  typedef enum logic {IDLE, IN_PACKET} state_t;

  state_t                  state;
  logic [PB_W-1:0]         pkt_beats;
  logic [ID_W-1:0]         lat_tid;
  logic [DEST_W-1:0]       lat_tdest;
  logic [ST_W-1:0]         stall_cnt;
  logic [ST_W-1:0]         stall_next;
  logic                    past_valid;
  logic                    prev_valid, prev_ready, prev_last;
  logic [8*byte_width-1:0] prev_data;
  logic [byte_width-1:0]   prev_strb, prev_keep;
  logic [ID_W-1:0]         prev_tid;
  logic [DEST_W-1:0]       prev_tdest;
  logic [USER_W-1:0]       prev_tuser;

  logic                    beat, stall, prev_stall, payload_diff, route_diff;
  logic [PB_W-1:0]         pkt_idx;
  logic [5:0]              new_err;
  logic [2:0]              first_code;

  assign beat       = tvalid & tready;
  assign stall      = tvalid & ~tready;
  assign prev_stall = prev_valid & ~prev_ready;
  assign in_packet  = (state == IN_PACKET);
  assign err_any    = |err_flags;

  // Violation detection for the current edge, plus the lowest-index code among them.
  always_comb begin
    payload_diff = (tdata != prev_data) || (tstrb != prev_strb) || (tkeep != prev_keep) ||
                   (tlast != prev_last) ||
                   ((id_width > 0) && (tid != prev_tid)) ||
                   ((dest_width > 0) && (tdest != prev_tdest)) ||
                   ((user_width > 0) && (tuser != prev_tuser));
    route_diff   = ((id_width > 0) && (tid != lat_tid)) ||
                   ((dest_width > 0) && (tdest != lat_tdest));
    if (!stall || (STALL_TIMEOUT == 0))
      stall_next = '0;
    else if (stall_cnt >= ST_MAX)
      stall_next = ST_MAX;
    else
      stall_next = stall_cnt + 1'b1;
    if (state == IDLE)
      pkt_idx = PB_W'(1);
    else if (pkt_beats == '1)
      pkt_idx = pkt_beats;
    else
      pkt_idx = pkt_beats + 1'b1;
    new_err    = '0;
    new_err[0] = past_valid & prev_stall & ~tvalid;
    new_err[1] = past_valid & prev_stall & tvalid & payload_diff;
    new_err[2] = tvalid & (|(tstrb & ~tkeep));
    new_err[3] = (STALL_TIMEOUT != 0) && stall && (stall_next == ST_MAX);
    new_err[4] = (MAX_PACKET_BEATS != 0) && beat && (pkt_idx > MAX_PB);
    new_err[5] = beat && (state == IN_PACKET) && route_diff;
    first_code = '0;
    for (int i = 5; i >= 0; i--)
      if (new_err[i]) first_code = 3'(i + 1);
  end

  // Previous-cycle copies of the link for the cycle-to-cycle checks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      past_valid <= 1'b0;
      prev_valid <= 1'b0;
      prev_ready <= 1'b0;
      prev_last  <= 1'b0;
      prev_data  <= '0;
      prev_strb  <= '0;
      prev_keep  <= '0;
      prev_tid   <= '0;
      prev_tdest <= '0;
      prev_tuser <= '0;
    end else begin
      past_valid <= 1'b1;
      prev_valid <= tvalid;
      prev_ready <= tready;
      prev_last  <= tlast;
      prev_data  <= tdata;
      prev_strb  <= tstrb;
      prev_keep  <= tkeep;
      prev_tid   <= tid;
      prev_tdest <= tdest;
      prev_tuser <= tuser;
    end
  end

  // Consecutive-stall counter; holds at the timeout value instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt <= '0;
    else       stall_cnt <= stall_next;
  end

  // Packet FSM with saturating statistics; clear_errors deliberately leaves these alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      pkt_beats    <= '0;
      lat_tid      <= '0;
      lat_tdest    <= '0;
      beat_count   <= '0;
      packet_count <= '0;
    end else if (beat) begin
      if (beat_count != '1) beat_count <= beat_count + 1'b1;
      if (tlast && (packet_count != '1)) packet_count <= packet_count + 1'b1;
      pkt_beats <= pkt_idx;
      case (state)
        IDLE: begin
          if (!tlast) begin
            state     <= IN_PACKET;
            lat_tid   <= tid;
            lat_tdest <= tdest;
          end
        end
        IN_PACKET: if (tlast) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  // Sticky flags and first-error capture; a new violation overrides a same-edge clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_flags <= '0;
      first_err <= '0;
    end else begin
      err_flags <= (clear_errors ? 6'b0 : err_flags) | new_err;
      if (clear_errors || (first_err == '0)) first_err <= first_code;
    end
  end

endmodule

// File: tb/tb_axi_stream_protocol_checker.sv
// Directed bench for axi_stream_protocol_checker. Stimulus pushes the expected
// post-edge outputs into a scoreboard; a monitor on the falling edge pops and compares.
module tb_axi_stream_protocol_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        tvalid, tready, tlast, clear_errors;
  logic [31:0] tdata;
  logic [3:0]  tstrb, tkeep;
  logic [1:0]  tid;
  logic        tdest, tuser;
  logic [5:0]  err_flags;
  logic        err_any;
  logic [2:0]  first_err;
  logic [31:0] beat_count, packet_count;
  logic        in_packet;

  axi_stream_protocol_checker #(
    .byte_width(4), .id_width(2), .dest_width(0), .user_width(0),
    .MAX_PACKET_BEATS(4), .STALL_TIMEOUT(8), .COUNT_WIDTH(32)
  ) dut (
    .clk(clk), .reset(rst), .tvalid(tvalid), .tready(tready), .tdata(tdata),
    .tstrb(tstrb), .tkeep(tkeep), .tlast(tlast), .tid(tid), .tdest(tdest),
    .tuser(tuser), .clear_errors(clear_errors), .err_flags(err_flags),
    .err_any(err_any), .first_err(first_err), .beat_count(beat_count),
    .packet_count(packet_count), .in_packet(in_packet)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          tag;
    logic [5:0]  f;
    logic [2:0]  fe;
    logic [31:0] bc;
    logic [31:0] pc;
    logic        ip;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   tag = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int t, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL test%0d %s: got %0h expected %0h (t=%0t)", t, nm, act, want, $time);
    end
  endtask

  // Monitor: compare every expectation that has come due.
  exp_t e;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      chk("err_flags", e.tag, 32'(err_flags), 32'(e.f));
      chk("err_any", e.tag, 32'(err_any), 32'(|e.f));
      chk("first_err", e.tag, 32'(first_err), 32'(e.fe));
      chk("beat_count", e.tag, beat_count, e.bc);
      chk("packet_count", e.tag, packet_count, e.pc);
      chk("in_packet", e.tag, 32'(in_packet), 32'(e.ip));
    end
  end

  task automatic push_exp(input int due, input logic [5:0] f, input logic [2:0] fe,
                          input int bc, input int pc, input logic ip);
    exp_t x;
    x.due = due; x.tag = tag; x.f = f; x.fe = fe;
    x.bc = 32'(bc); x.pc = 32'(pc); x.ip = ip;
    sb.push_back(x);
  endtask

  task automatic set_in(input logic v, input logic r, input logic [31:0] d, input logic [3:0] s,
                        input logic [3:0] k, input logic l, input logic [1:0] id, input logic clr);
    tvalid = v; tready = r; tdata = d; tstrb = s; tkeep = k; tlast = l; tid = id; clear_errors = clr;
  endtask

  // One clock with the current inputs; optionally expect the outputs after this edge.
  task automatic step(input bit do_chk, input logic [5:0] f, input logic [2:0] fe,
                      input int bc, input int pc, input logic ip);
    if (do_chk) push_exp(cyc + 1, f, fe, bc, pc, ip);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tdest = 1'b0; tuser = 1'b0;
    set_in(0, 0, 32'h0, 4'hF, 4'hF, 0, 2'd0, 0);
    tag = 0;
    repeat (3) step(1, 6'd0, 3'd0, 0, 0, 0);
    rst = 1'b0;

    // 1: four-beat packet, no errors
    tag = 1;
    set_in(1, 1, 32'h11, 4'hF, 4'hF, 0, 2'd0, 0); step(1, 6'd0, 3'd0, 1, 0, 1);
    set_in(1, 1, 32'h22, 4'hF, 4'hF, 0, 2'd0, 0); step(1, 6'd0, 3'd0, 2, 0, 1);
    set_in(1, 1, 32'h33, 4'hF, 4'hF, 0, 2'd0, 0); step(1, 6'd0, 3'd0, 3, 0, 1);
    set_in(1, 1, 32'h44, 4'hF, 4'hF, 1, 2'd0, 0); step(1, 6'd0, 3'd0, 4, 1, 0);
    set_in(0, 0, 32'h0, 4'hF, 4'hF, 0, 2'd0, 0);  step(1, 6'd0, 3'd0, 4, 1, 0);

    // 2: valid dropped during a stall, then clear
    tag = 2;
    set_in(1, 0, 32'hA5A5A5A5, 4'hF, 4'hF, 0, 2'd0, 0); step(1, 6'd0, 3'd0, 4, 1, 0);
    set_in(0, 0, 32'hA5A5A5A5, 4'hF, 4'hF, 0, 2'd0, 0); step(1, 6'd1, 3'd1, 4, 1, 0);
    set_in(0, 0, 32'h0, 4'hF, 4'hF, 0, 2'd0, 1);        step(1, 6'd0, 3'd0, 4, 1, 0);
    set_in(0, 0, 32'h0, 4'hF, 4'hF, 0, 2'd0, 0);        step(1, 6'd0, 3'd0, 4, 1, 0);

    // 3: payload change and strobe-without-keep on the same edge
    tag = 3;
    set_in(1, 0, 32'hA5A5A5A5, 4'hF, 4'hF, 0, 2'd0, 0); step(1, 6'd0, 3'd0, 4, 1, 0);
    set_in(1, 0, 32'h5A5A5A5A, 4'h3, 4'h1, 0, 2'd0, 0); step(1, 6'b000110, 3'd2, 4, 1, 0);
    set_in(1, 1, 32'h5A5A5A5A, 4'h3, 4'h1, 1, 2'd0, 0); step(1, 6'b000110, 3'd2, 5, 2, 0);
    set_in(0, 0, 32'h0, 4'hF, 4'hF, 0, 2'd0, 1);        step(1, 6'd0, 3'd0, 5, 2, 0);

    // 4: stall timeout fires on the 8th stalled edge, not the 7th
    tag = 4;
    set_in(1, 0, 32'hC0FFEE00, 4'hF, 4'hF, 1, 2'd0, 0);
    repeat (7) step(1, 6'd0, 3'd0, 5, 2, 0);
    step(1, 6'b001000, 3'd4, 5, 2, 0);
    set_in(1, 1, 32'hC0FFEE00, 4'hF, 4'hF, 1, 2'd0, 0); step(1, 6'b001000, 3'd4, 6, 3, 0);
    set_in(0, 0, 32'h0, 4'hF, 4'hF, 0, 2'd0, 1);        step(1, 6'd0, 3'd0, 6, 3, 0);
    set_in(0, 0, 32'h0, 4'hF, 4'hF, 0, 2'd0, 0);        step(1, 6'd0, 3'd0, 6, 3, 0);

    // 5: route change on beat 3, over-length on beat 5
    tag = 5;
    set_in(1, 1, 32'h1, 4'hF, 4'hF, 0, 2'd1, 0); step(1, 6'd0, 3'd0, 7, 3, 1);
    set_in(1, 1, 32'h2, 4'hF, 4'hF, 0, 2'd1, 0); step(1, 6'd0, 3'd0, 8, 3, 1);
    set_in(1, 1, 32'h3, 4'hF, 4'hF, 0, 2'd2, 0); step(1, 6'b100000, 3'd6, 9, 3, 1);
    set_in(1, 1, 32'h4, 4'hF, 4'hF, 0, 2'd2, 0); step(1, 6'b100000, 3'd6, 10, 3, 1);
    set_in(1, 1, 32'h5, 4'hF, 4'hF, 1, 2'd2, 0); step(1, 6'b110000, 3'd6, 11, 4, 0);

    // 6: asynchronous reset in the middle of an open packet
    tag = 6;
    set_in(1, 1, 32'h6, 4'hF, 4'hF, 0, 2'd0, 0); step(1, 6'b110000, 3'd6, 12, 4, 1);
    set_in(0, 0, 32'h0, 4'hF, 4'hF, 0, 2'd0, 0); step(0, 6'd0, 3'd0, 0, 0, 0);
    rst = 1'b1;
    push_exp(cyc, 6'd0, 3'd0, 0, 0, 0);
    step(1, 6'd0, 3'd0, 0, 0, 0);
    rst = 1'b0;
    step(1, 6'd0, 3'd0, 0, 0, 0);
    set_in(1, 1, 32'h7, 4'hF, 4'hF, 1, 2'd3, 0); step(1, 6'd0, 3'd0, 1, 1, 0);
    set_in(0, 0, 32'h0, 4'hF, 4'hF, 0, 2'd0, 0); step(1, 6'd0, 3'd0, 1, 1, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
